bsr_meta_loader: RTL and testbench
==================================

Name: bsr_meta_loader

Overview:
- Writer side of the BSR metadata store: accepts a packed metadata stream from the DMA and writes row pointers and column indices into the metadata BRAM.
- meta_decode later reads these entries back for the scheduler.
- Validates stream structure and reports the matrix dimensions it loaded.
- Pulses a cache-invalidate so stale cached metadata in the reader is dropped.

Parameters:
- DATA_WIDTH, 32, stream and BRAM word width.
- ADDR_WIDTH, 16, BRAM word address width.
- MAX_ROWS, 1024, maximum block rows accepted.
- MAX_NNZ, 16384, maximum nonzero blocks accepted.
- COL_IDX_BASE, 16'h2000, BRAM word address of column index region; the row pointer region starts at 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a load, ignored unless in S_IDLE
- num_block_cols  in  16  column count used to range-check column indices; sampled at start
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  stream word
- in_last  in  1  marks final stream word
- mem_we  out  1  BRAM write enable (registered)
- mem_waddr  out  ADDR_WIDTH  BRAM write address (registered)
- mem_wdata  out  DATA_WIDTH  BRAM write data (registered)
- busy  out  1  high from accepted start until S_DONE/S_ERR exit
- done  out  1  one-cycle pulse on successful load
- error  out  1  sticky until next accepted start or rst
- err_code  out  3  0 none, 1 rows>MAX_ROWS, 2 row_ptr[0]!=0, 3 row_ptr decreasing, 4 nnz>MAX_NNZ, 5 col>=num_block_cols, 6 early in_last, 7 missing in_last
- rows_loaded  out  16  block rows R of last successful load
- nnz_loaded  out  ADDR_WIDTH+1  nnz of last successful load
- cache_inv  out  1  one-cycle pulse together with done

Behaviour:
- Stream format:
  - word0 = R (block rows);
  - next R+1 words = row_ptr[0..R];
  - next nnz words = col_idx, where nnz = row_ptr[R];
  - in_last on the final word only.
- FSM states: S_IDLE, S_HDR, S_ROWPTR, S_COLIDX, S_DONE, S_ERR. One-hot encoding.
- S_IDLE:
  - in_ready=0.
  - start -> S_HDR: clear error/err_code, latch num_block_cols, zero counters.
- S_HDR:
  - in_ready=1.
  - On a beat: R>MAX_ROWS or R==0 -> S_ERR code 1; in_last -> S_ERR code 6; else latch R -> S_ROWPTR.
  - The header is not written to BRAM.
- S_ROWPTR:
  - in_ready=1.
  - Each beat writes in_data to address rp_cnt, rp_cnt++.
  - Checks: beat 0 must equal 0 (code 2); each value must be >= the previous (code 3).
  - On the beat with rp_cnt==R: value>MAX_NNZ -> code 4; latch nnz.
    - nnz==0 && in_last -> S_DONE.
    - nnz==0 && !in_last -> code 7.
    - nnz>0 && in_last -> code 6.
    - else -> S_COLIDX.
  - in_last on any earlier beat -> code 6.
- S_COLIDX:
  - in_ready=1.
  - Each beat writes to COL_IDX_BASE+ci_cnt, ci_cnt++.
  - in_data>=num_block_cols -> code 5.
  - Last expected beat (ci_cnt==nnz-1): in_last -> S_DONE; else code 7.
  - in_last on an earlier beat -> code 6.
- S_DONE:
  - One cycle: done=1, cache_inv=1, update rows_loaded/nnz_loaded -> S_IDLE.
- S_ERR:
  - in_ready=1; drains beats silently (no writes) until an in_last beat, then -> S_IDLE.
  - If the error beat itself carried in_last, go directly S_IDLE.
  - rows_loaded/nnz_loaded unchanged; no cache_inv.
- Write pipeline:
  - mem_we/mem_waddr/mem_wdata registered; the write appears one cycle after the accepting beat.
  - A beat that raises an error is not written.
  - The BRAM write port never backpressures.
- Throughput: one beat per cycle when in_valid is held; load latency = total words + 1 cycle (S_DONE).
- busy: 1 in S_HDR, S_ROWPTR, S_COLIDX, S_DONE, S_ERR.
- start is ignored while busy.
- Comparisons are unsigned. Counters are ADDR_WIDTH+1 wide, so there is no wrap at MAX_NNZ.
- Reset mid-load:
  - rst forces S_IDLE and clears all outputs.
  - Partially written BRAM contents are undefined; no done is issued.
- Reset values: in_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, busy 0, done 0, error 0, err_code 0, rows_loaded 0, nnz_loaded 0, cache_inv 0.

Decomposition:
- Shared package bsr_meta_pkg holds:
  - state localparams;
  - err_code constants;
  - COL_IDX_BASE default;
  - the stream format field definitions.
- The reader side uses the same base constants from this package.
- Sub-module meta_wr_stage: a registered BRAM write port with a squash input for error beats. It is a natural reusable split.

Test Plan:
- R=2, stream [2,0,1,3,5,7,9] with last on 9, num_block_cols=10:
  - writes addr0..2 = 0,1,3;
  - writes 0x2000..0x2002 = 5,7,9;
  - done and cache_inv pulse; rows_loaded=2, nnz_loaded=3.
- Stream [2,0,2,1,...]: error, err_code=3, no write for 1; remaining beats drained until last; return to idle; next start loads cleanly.
- Stream [1,0,0] with last on the final 0: done with nnz_loaded=0, no column writes.
- Column 12 with num_block_cols=10: err_code=5, cache_inv stays 0.
- in_last asserted on row_ptr[1] with R=3: err_code=6.
- Good stream with in_valid toggling every other cycle: identical writes and done.
- rst asserted mid-S_COLIDX: next cycle all outputs are at reset values and in_ready=0.

Source files
------------

// File: rtl/bsr_meta_pkg.sv
// Shared definitions for the BSR metadata store (writer and reader sides).
// Covers FSM states, error codes, BRAM region bases and stream layout.
package bsr_meta_pkg;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_HDR    = 6'b000010,
        S_ROWPTR = 6'b000100,
        S_COLIDX = 6'b001000,
        S_DONE   = 6'b010000,
        S_ERR    = 6'b100000
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_ROWS       = 3'd1,
        ERR_RP0        = 3'd2,
        ERR_RP_DEC     = 3'd3,
        ERR_NNZ        = 3'd4,
        ERR_COL        = 3'd5,
        ERR_EARLY_LAST = 3'd6,
        ERR_NO_LAST    = 3'd7
    } err_t;

    localparam logic [15:0] ROW_PTR_BASE     = 16'h0000;
    localparam logic [15:0] COL_IDX_BASE_DEF = 16'h2000;

    // Stream: one header word (R), R+1 row pointers, then nnz column indices.
    localparam int unsigned HDR_WORDS = 1;

    function automatic int unsigned stream_words(input int unsigned rows,
                                                 input int unsigned nnz);
        return HDR_WORDS + rows + 1 + nnz;
    endfunction

endpackage

// File: rtl/bsr_meta_loader_if.sv
// Valid/ready metadata stream from the DMA into the metadata loader.
interface bsr_meta_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/meta_wr_stage.sv
// Registered BRAM write port; a squashed request produces no write.
module meta_wr_stage #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  squash,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    always_comb begin
        we_d    = wr_en && !squash;
        waddr_d = we_d ? wr_addr : waddr_q;
        wdata_d = we_d ? wr_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: rtl/bsr_meta_loader.sv
// Writes a packed BSR metadata stream (row pointers, column indices) into the
// metadata BRAM, validating structure and reporting the loaded dimensions.
module bsr_meta_loader
    import bsr_meta_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter int unsigned           MAX_ROWS     = 1024,
    parameter int unsigned           MAX_NNZ      = 16384,
    parameter logic [ADDR_WIDTH-1:0] COL_IDX_BASE = ADDR_WIDTH'(COL_IDX_BASE_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           num_block_cols,
    bsr_meta_loader_if.slave      in_if,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_code,
    output logic [15:0]           rows_loaded,
    output logic [ADDR_WIDTH:0]   nnz_loaded,
    output logic                  cache_inv
);
    localparam int unsigned CW = ADDR_WIDTH + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   r_q, r_d, nnz_q, nnz_d, rp_cnt_q, rp_cnt_d, ci_cnt_q, ci_cnt_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [15:0]     ncols_q, ncols_d, rows_loaded_q, rows_loaded_d;
    logic [CW-1:0]   nnz_loaded_q, nnz_loaded_d;
    logic            error_q, error_d;
    err_t            err_code_q, err_code_d, code;
    logic            ready, beat, raise, wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        nnz_d         = nnz_q;
        rp_cnt_d      = rp_cnt_q;
        ci_cnt_d      = ci_cnt_q;
        prev_d        = prev_q;
        ncols_d       = ncols_q;
        rows_loaded_d = rows_loaded_q;
        nnz_loaded_d  = nnz_loaded_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        code          = ERR_NONE;
        raise         = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        ready = (state_q == S_HDR) || (state_q == S_ROWPTR) ||
                (state_q == S_COLIDX) || (state_q == S_ERR);
        beat  = in_if.in_valid && ready;

        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_HDR;
                error_d    = 1'b0;
                err_code_d = ERR_NONE;
                ncols_d    = num_block_cols;
                r_d        = '0;
                nnz_d      = '0;
                rp_cnt_d   = '0;
                ci_cnt_d   = '0;
                prev_d     = '0;
            end
            S_HDR: if (beat) begin
                if (in_if.in_data > DATA_WIDTH'(MAX_ROWS) || in_if.in_data == '0) begin
                    raise = 1'b1; code = ERR_ROWS;
                end else if (in_if.in_last) begin
                    raise = 1'b1; code = ERR_EARLY_LAST;
                end else begin
                    r_d     = in_if.in_data[CW-1:0];
                    state_d = S_ROWPTR;
                end
            end
            S_ROWPTR: if (beat) begin
                wr_en    = 1'b1;
                wr_addr  = ADDR_WIDTH'(ROW_PTR_BASE) + rp_cnt_q[ADDR_WIDTH-1:0];
                rp_cnt_d = rp_cnt_q + CW'(1);
                prev_d   = in_if.in_data;
                if (rp_cnt_q == '0 && in_if.in_data != '0) begin
                    raise = 1'b1; code = ERR_RP0;
                end else if (in_if.in_data < prev_q) begin
                    raise = 1'b1; code = ERR_RP_DEC;
                end else if (rp_cnt_q == r_q) begin
                    if (in_if.in_data > DATA_WIDTH'(MAX_NNZ)) begin
                        raise = 1'b1; code = ERR_NNZ;
                    end else begin
                        nnz_d = in_if.in_data[CW-1:0];
                        if (in_if.in_data == '0) begin
                            if (in_if.in_last) begin
                                state_d       = S_DONE;
                                rows_loaded_d = r_q[15:0];
                                nnz_loaded_d  = '0;
                            end else begin
                                raise = 1'b1; code = ERR_NO_LAST;
                            end
                        end else if (in_if.in_last) begin
                            raise = 1'b1; code = ERR_EARLY_LAST;
                        end else begin
                            state_d = S_COLIDX;
                        end
                    end
                end else if (in_if.in_last) begin
                    raise = 1'b1; code = ERR_EARLY_LAST;
                end
            end
            S_COLIDX: if (beat) begin
                wr_en    = 1'b1;
                wr_addr  = COL_IDX_BASE + ci_cnt_q[ADDR_WIDTH-1:0];
                ci_cnt_d = ci_cnt_q + CW'(1);
                if (in_if.in_data >= DATA_WIDTH'(ncols_q)) begin
                    raise = 1'b1; code = ERR_COL;
                end else if (ci_cnt_q + CW'(1) == nnz_q) begin
                    if (in_if.in_last) begin
                        state_d       = S_DONE;
                        rows_loaded_d = r_q[15:0];
                        nnz_loaded_d  = nnz_q;
                    end else begin
                        raise = 1'b1; code = ERR_NO_LAST;
                    end
                end else if (in_if.in_last) begin
                    raise = 1'b1; code = ERR_EARLY_LAST;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   if (beat && in_if.in_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An offending beat is squashed; if it already ends the stream there is nothing to drain.
        if (raise) begin
            error_d    = 1'b1;
            err_code_d = code;
            state_d    = in_if.in_last ? S_IDLE : S_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            r_q           <= '0;
            nnz_q         <= '0;
            rp_cnt_q      <= '0;
            ci_cnt_q      <= '0;
            prev_q        <= '0;
            ncols_q       <= '0;
            rows_loaded_q <= '0;
            nnz_loaded_q  <= '0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            nnz_q         <= nnz_d;
            rp_cnt_q      <= rp_cnt_d;
            ci_cnt_q      <= ci_cnt_d;
            prev_q        <= prev_d;
            ncols_q       <= ncols_d;
            rows_loaded_q <= rows_loaded_d;
            nnz_loaded_q  <= nnz_loaded_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    meta_wr_stage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .squash    (raise),
        .wr_addr   (wr_addr),
        .wr_data   (in_if.in_data),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    assign in_if.in_ready = ready;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign cache_inv      = (state_q == S_DONE);
    assign error          = error_q;
    assign err_code       = err_code_q;
    assign rows_loaded    = rows_loaded_q;
    assign nnz_loaded     = nnz_loaded_q;
endmodule

// File: tb/tb_bsr_meta_loader.sv
// Scoreboard bench: stimulus queues expected BRAM writes and load outcomes,
// a negedge monitor pops and compares them as the loader produces them.
module tb_bsr_meta_loader;
    import bsr_meta_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_block_cols = '0;
    logic        mem_we, busy, done, error, cache_inv;
    logic [15:0] mem_waddr, rows_loaded;
    logic [31:0] mem_wdata;
    logic [2:0]  err_code;
    logic [16:0] nnz_loaded;

    bsr_meta_loader_if #(.DATA_WIDTH(32)) sif ();

    bsr_meta_loader #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (16),
        .MAX_ROWS     (1024),
        .MAX_NNZ      (16384),
        .COL_IDX_BASE (16'h2000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_block_cols (num_block_cols),
        .in_if          (sif.slave),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code),
        .rows_loaded    (rows_loaded),
        .nnz_loaded     (nnz_loaded),
        .cache_inv      (cache_inv)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
    typedef struct { bit is_err; logic [2:0] code; logic [15:0] rows; logic [16:0] nnz; } out_t;

    wr_t         wq[$];
    out_t        oq[$];
    logic [31:0] stim[$];
    wr_t         mw;
    out_t        mo;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        err_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ew(input int unsigned a, input int unsigned d);
        wr_t t;
        t.a = a[15:0];
        t.d = d;
        wq.push_back(t);
    endtask

    task automatic exp_done(input int unsigned r, input int unsigned n);
        out_t o;
        o.is_err = 1'b0; o.code = 3'd0; o.rows = r[15:0]; o.nnz = n[16:0];
        oq.push_back(o);
    endtask

    task automatic exp_err(input int unsigned c);
        out_t o;
        o.is_err = 1'b1; o.code = c[2:0]; o.rows = '0; o.nnz = '0;
        oq.push_back(o);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                chk("wr_expected", 64'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    mw = wq.pop_front();
                    chk("wr_addr", 64'(mem_waddr), 64'(mw.a));
                    chk("wr_data", 64'(mem_wdata), 64'(mw.d));
                end
            end
            if (done || cache_inv) begin
                chk("done", 64'(done), 1);
                chk("cache_inv", 64'(cache_inv), 1);
                chk("done_expected", 64'(oq.size() != 0), 1);
                if (oq.size() != 0) begin
                    mo = oq.pop_front();
                    chk("outcome_is_done", 64'(mo.is_err), 0);
                    chk("rows_loaded", 64'(rows_loaded), 64'(mo.rows));
                    chk("nnz_loaded", 64'(nnz_loaded), 64'(mo.nnz));
                end
            end
            if (error && !err_prev) begin
                chk("err_expected", 64'(oq.size() != 0), 1);
                if (oq.size() != 0) begin
                    mo = oq.pop_front();
                    chk("outcome_is_err", 64'(mo.is_err), 1);
                    chk("err_code", 64'(err_code), 64'(mo.code));
                end
            end
        end
        err_prev = error;
    end

    task automatic do_start(input logic [15:0] nc);
        @(negedge clk);
        start = 1'b1;
        num_block_cols = nc;
        @(negedge clk);
        start = 1'b0;
        num_block_cols = '0;
        chk("busy_after_start", 64'(busy), 1);
        chk("error_cleared", 64'(error), 0);
        chk("err_code_cleared", 64'(err_code), 0);
    endtask

    task automatic send_stream(input int n, input int last_idx, input int gap);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            sif.in_valid = 1'b1;
            sif.in_data  = stim[i];
            sif.in_last  = (i == last_idx);
            while (!sif.in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!sif.in_ready) begin
                chk("in_ready_timeout", 64'(sif.in_ready), 1);
                sif.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            sif.in_valid = 1'b0;
            sif.in_last  = 1'b0;
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("busy_idle", 64'(busy), 0);
        chk("in_ready_idle", 64'(sif.in_ready), 0);
    endtask

    task automatic good_load(input int gap);
        stim = '{32'd2, 32'd0, 32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
        ew(0, 0); ew(1, 1); ew(2, 3); ew(16'h2000, 5); ew(16'h2001, 7); ew(16'h2002, 9);
        exp_done(2, 3);
        do_start(16'd10);
        send_stream(7, 6, gap);
        wait_idle();
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(sif.in_ready), 0);
        chk("rst_mem_we", 64'(mem_we), 0);
        chk("rst_mem_waddr", 64'(mem_waddr), 0);
        chk("rst_mem_wdata", 64'(mem_wdata), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_error", 64'(error), 0);
        chk("rst_err_code", 64'(err_code), 0);
        chk("rst_rows_loaded", 64'(rows_loaded), 0);
        chk("rst_nnz_loaded", 64'(nnz_loaded), 0);
        chk("rst_cache_inv", 64'(cache_inv), 0);
        rst = 1'b0;

        // Good load, back-to-back beats, with start-to-done latency check.
        stim = '{32'd2, 32'd0, 32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
        ew(0, 0); ew(1, 1); ew(2, 3); ew(16'h2000, 5); ew(16'h2001, 7); ew(16'h2002, 9);
        exp_done(2, 3);
        do_start(16'd10);
        fork
            send_stream(7, 6, 0);
            begin
                int c = 0;
                while (!done && c < 50) begin
                    @(negedge clk);
                    c++;
                end
                chk("done_latency", 64'(c), 64'(stream_words(2, 3)));
            end
        join
        wait_idle();

        // Decreasing row pointer, then drain to in_last.
        stim = '{32'd2, 32'd0, 32'd2, 32'd1, 32'd5, 32'd7, 32'd9};
        ew(0, 0); ew(1, 2);
        exp_err(3);
        do_start(16'd10);
        send_stream(7, 6, 0);
        wait_idle();

        // Empty matrix: nnz == 0, no column writes.
        stim = '{32'd1, 32'd0, 32'd0};
        ew(0, 0); ew(1, 0);
        exp_done(1, 0);
        do_start(16'd10);
        send_stream(3, 2, 0);
        wait_idle();

        // Column out of range on the final beat.
        stim = '{32'd1, 32'd0, 32'd2, 32'd3, 32'd12};
        ew(0, 0); ew(1, 2); ew(16'h2000, 3);
        exp_err(5);
        do_start(16'd10);
        send_stream(5, 4, 0);
        wait_idle();
        chk("rows_loaded_kept", 64'(rows_loaded), 1);
        chk("nnz_loaded_kept", 64'(nnz_loaded), 0);

        // Early in_last on row_ptr[1] with R=3.
        stim = '{32'd3, 32'd0, 32'd1};
        ew(0, 0);
        exp_err(6);
        do_start(16'd10);
        send_stream(3, 2, 0);
        wait_idle();

        // Missing in_last on the final column, then drained.
        stim = '{32'd1, 32'd0, 32'd1, 32'd4, 32'd9};
        ew(0, 0); ew(1, 1);
        exp_err(7);
        do_start(16'd10);
        send_stream(5, 4, 0);
        wait_idle();

        // Header limits: R == 0 and R == MAX_ROWS+1.
        stim = '{32'd0};
        exp_err(1);
        do_start(16'd10);
        send_stream(1, 0, 0);
        wait_idle();
        stim = '{32'd1025, 32'd5};
        exp_err(1);
        do_start(16'd10);
        send_stream(2, 1, 0);
        wait_idle();

        // nnz one beyond MAX_NNZ.
        stim = '{32'd1, 32'd0, 32'd16385};
        ew(0, 0);
        exp_err(4);
        do_start(16'd10);
        send_stream(3, 2, 0);
        wait_idle();

        // Same good load with a bubble after every beat.
        good_load(1);

        // Reset in the middle of the column region.
        stim = '{32'd2, 32'd0, 32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
        ew(0, 0); ew(1, 1); ew(2, 3); ew(16'h2000, 5);
        do_start(16'd10);
        send_stream(5, 99, 0);
        @(negedge clk);
        rst = 1'b1;
        sif.in_valid = 1'b1;
        sif.in_data  = 32'd7;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(sif.in_ready), 0);
        chk("mid_rst_mem_we", 64'(mem_we), 0);
        chk("mid_rst_mem_waddr", 64'(mem_waddr), 0);
        chk("mid_rst_mem_wdata", 64'(mem_wdata), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        chk("mid_rst_error", 64'(error), 0);
        chk("mid_rst_err_code", 64'(err_code), 0);
        chk("mid_rst_rows_loaded", 64'(rows_loaded), 0);
        chk("mid_rst_nnz_loaded", 64'(nnz_loaded), 0);
        chk("mid_rst_cache_inv", 64'(cache_inv), 0);
        sif.in_valid = 1'b0;
        rst = 1'b0;

        good_load(0);

        repeat (5) @(negedge clk);
        chk("writes_pending", 64'(wq.size()), 0);
        chk("outcomes_pending", 64'(oq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
